alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational MIPS ALU (existing `alu` module) between NUM_REQ independent requesters, e.g. the main execute path, the branch-compare path and the address-calculation path.
- Each requester has a valid/ready request channel; results return on a single registered response channel tagged with the requester ID.
- Arbitration is round-robin, one operation is accepted per cycle, and the response register is a one-deep pipeline stage with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- WORD_SIZE, 32, operand/result width; must match the ALU word size.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_alu_control  input  4*NUM_REQ  packed ALU opcodes; requester i occupies bits [4i+3:4i].
- req_a  input  WORD_SIZE*NUM_REQ  packed operand A per requester.
- req_b  input  WORD_SIZE*NUM_REQ  packed operand B per requester.
- resp_valid  output  1  response register holds a result.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  ID_W  index of the requester that issued the result.
- resp_result  output  WORD_SIZE  ALU result.
- resp_zero  output  1  ALU zero flag for the result.
- grant_count  output  16  total accepted operations; wraps modulo 2**16.

Behaviour:
- Reset (async, rst_n=0): resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, grant_count=0, rr_ptr=0. req_ready is combinational and is 0 while reset is asserted.
- Accept condition: can_accept = !resp_valid || resp_ready.
- Arbitration:
  - When can_accept=1, grant goes to the first i with req_valid[i]=1, searching cyclically from rr_ptr.
  - req_ready[grant]=1; all other bits are 0.
  - If no requester is valid, req_ready is all 0.
- Round-robin pointer: on a handshake, rr_ptr <= grant+1, wrapping from NUM_REQ-1 to 0. With no handshake, rr_ptr holds.
- Datapath:
  - The granted requester's opcode and operands are muxed into a single `alu` instance.
  - On a handshake, resp_result, resp_zero and resp_id are registered and resp_valid <= 1.
  - Latency: 1 cycle from handshake to resp_valid.
- Response drain:
  - If resp_valid && resp_ready and no new handshake, resp_valid <= 0.
  - Simultaneous drain and accept: the register reloads and resp_valid stays 1. Full throughput is one op per cycle.
- Backpressure: when resp_valid=1 and resp_ready=0:
  - req_ready is all 0.
  - Response outputs hold stable.
  - rr_ptr holds.
- Handshake rules:
  - Requesters must hold valid and payload until ready.
  - req_ready may depend on req_valid; it never depends on payload.
- Opcodes: unsupported alu_control values produce result 0, zero=1, matching ALU default behaviour. No error flag.
- grant_count increments by 1 per handshake and wraps 0xFFFF -> 0x0000.
- Reset mid-operation: any pending response is discarded and no partial state survives.
- Fairness: a continuously valid requester is granted within NUM_REQ accepting cycles.

Decomposition:
- Shared package holds:
  - ALU opcode constants: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - WORD_SIZE.
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs req vector, enable and pointer; outputs one-hot grant and encoded index.
- Existing `alu` is instantiated unchanged.

Test Plan:
- Single op: req 0 valid, ADD, a=5, b=7, resp_ready=1. Expect req_ready[0]=1 that cycle; next cycle resp_valid=1, result=12, zero=0, id=0; grant_count=1.
- Round-robin: all 4 requesters valid continuously with SUB a=i, b=i. Expect grant order 0,1,2,3,0,… and result=0, zero=1 each time, one response per cycle.
- Backpressure: hold resp_ready=0 after one SLT, a=0xFFFFFFFF (-1), b=1. Expect result=1 held stable and req_ready=0 for 5 cycles. Raise resp_ready and expect the next grant the same cycle.
- Pointer wrap and skip: only requesters 1 and 3 valid, with rr_ptr=2. Expect grant 3, then 1, then 3.
- Counter wrap and invalid opcode:
  - Preload via 65535 ops, then one more: grant_count goes 0xFFFF -> 0x0000.
  - Opcode 4'b1111 with any operands gives result=0, zero=1.
- Async reset mid-stream: assert rst_n=0 between clock edges while resp_valid=1. Expect resp_valid=0 and all outputs 0 immediately. After release, expect first grant to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the arbitrated ALU slice: MIPS ALU opcodes and datapath width.
package alu_share_arbiter_pkg;

    localparam int unsigned WORD_SIZE = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU; unsupported opcodes yield a zero result.
module alu #(
    parameter int unsigned WORD_SIZE = alu_share_arbiter_pkg::WORD_SIZE
) (
    input  logic [3:0]           alu_control,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero
);
    import alu_share_arbiter_pkg::*;

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid request at or after ptr.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    logic found;

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Cyclic search without a modulo: ptr is always below NUM_REQ.
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (en && !found && req[j]) begin
                grant[j] = 1'b1;
                idx      = ID_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a
// one-deep registered, backpressured response stage.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned WORD_SIZE = alu_share_arbiter_pkg::WORD_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [4*NUM_REQ-1:0]         req_alu_control,
    input  logic [WORD_SIZE*NUM_REQ-1:0] req_a,
    input  logic [WORD_SIZE*NUM_REQ-1:0] req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
    output logic [WORD_SIZE-1:0]         resp_result,
    output logic                         resp_zero,
    output logic [15:0]                  grant_count
);
    logic                 can_accept;
    logic                 hs;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      gidx;
    logic [ID_W-1:0]      rr_ptr;
    logic [3:0]           alu_op;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_zero;

    assign can_accept = !resp_valid || resp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .en    (can_accept),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = rst_n ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        alu_op = req_alu_control[4*int'(gidx) +: 4];
        alu_a  = req_a[WORD_SIZE*int'(gidx) +: WORD_SIZE];
        alu_b  = req_b[WORD_SIZE*int'(gidx) +: WORD_SIZE];
    end

    alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .alu_control (alu_op),
        .a           (alu_a),
        .b           (alu_b),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            grant_count <= '0;
            rr_ptr      <= '0;
        end else if (hs) begin
            resp_valid  <= 1'b1;
            resp_id     <= gidx;
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            grant_count <= grant_count + 16'd1;
            rr_ptr      <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table-driven bench for alu_share_arbiter plus reset, counter-wrap sequences.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  req_alu_control;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [31:0]  resp_result;
    logic         resp_zero;
    logic [15:0]  grant_count;

    int n_cmp;
    int n_bad;

    alu_share_arbiter #(
        .NUM_REQ   (4),
        .ID_W      (2),
        .WORD_SIZE (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_alu_control (req_alu_control),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_result     (resp_result),
        .resp_zero       (resp_zero),
        .grant_count     (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rready;
        logic [3:0]  ready;
        logic        rv;
        logic [1:0]  id;
        logic [31:0] res;
        logic        z;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requester i sees operands a+16*i and b+16*i, so a wrong mux select is visible.
    task automatic drive(input logic [3:0] v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic rr);
        req_valid  = v;
        resp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            req_alu_control[4*i +: 4] = op;
            req_a[32*i +: 32]         = a + 32'(16 * i);
            req_b[32*i +: 32]         = b + 32'(16 * i);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rv, input logic [1:0] id,
                            input logic [31:0] res, input logic z, input logic [15:0] cnt);
        chk({tag, ".resp_valid"},  32'(resp_valid),  32'(rv));
        chk({tag, ".resp_id"},     32'(resp_id),     32'(id));
        chk({tag, ".resp_result"}, resp_result,      res);
        chk({tag, ".resp_zero"},   32'(resp_zero),   32'(z));
        chk({tag, ".grant_count"}, 32'(grant_count), 32'(cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        tbl[0]  = '{4'b0001, ALU_ADD, 32'd5,  32'd7, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd12,       1'b0, 16'd1};
        tbl[1]  = '{4'b1111, ALU_SUB, 32'd0,  32'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd0,        1'b1, 16'd2};
        tbl[2]  = '{4'b1111, ALU_SUB, 32'd0,  32'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd0,        1'b1, 16'd3};
        tbl[3]  = '{4'b1111, ALU_SUB, 32'd0,  32'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd0,        1'b1, 16'd4};
        tbl[4]  = '{4'b1111, ALU_SUB, 32'd0,  32'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0,        1'b1, 16'd5};
        tbl[5]  = '{4'b0000, ALU_SUB, 32'd0,  32'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0,        1'b1, 16'd5};
        tbl[6]  = '{4'b0010, ALU_ADD, 32'd1,  32'd2, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd35,       1'b0, 16'd6};
        tbl[7]  = '{4'b1010, ALU_OR,  32'd1,  32'd2, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd51,       1'b0, 16'd7};
        tbl[8]  = '{4'b1010, ALU_AND, 32'd1,  32'd2, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd16,       1'b0, 16'd8};
        tbl[9]  = '{4'b1010, ALU_NOR, 32'd0,  32'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hFFFFFFCF, 1'b0, 16'd9};
        tbl[10] = '{4'b0100, 4'b1111, 32'd5,  32'd9, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd0,        1'b1, 16'd10};
        tbl[11] = '{4'b0001, ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd1,  1'b0, 16'd11};
        for (int i = 12; i < 17; i++)
            tbl[i] = '{4'b1111, ALU_SLT, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd1,     1'b0, 16'd11};
        tbl[17] = '{4'b0100, ALU_ADD, 32'd2,  32'd3, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd69,       1'b0, 16'd12};
        tbl[18] = '{4'b1000, ALU_SLT, 32'd5,  32'd1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd0,        1'b1, 16'd13};
        tbl[19] = '{4'b0001, ALU_SUB, 32'd3,  32'd5, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hFFFFFFFE, 1'b0, 16'd14};

        // Reset state, with every requester asking.
        rst_n = 1'b0;
        drive(4'b1111, ALU_ADD, 32'd1, 32'd1, 1'b1);
        #2;
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk_outs("reset", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rready);
            #1;
            chk($sformatf("row%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            @(posedge clk);
            #1;
            chk_outs($sformatf("row%0d", i), tbl[i].rv, tbl[i].id, tbl[i].res, tbl[i].z, tbl[i].cnt);
            @(negedge clk);
        end

        // Counter wrap: requester 0 alone, one handshake every cycle.
        drive(4'b0001, ALU_ADD, 32'd5, 32'd7, 1'b1);
        repeat (65521) @(posedge clk);
        #1;
        chk("wrap.pre", 32'(grant_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        chk("wrap.post", 32'(grant_count), 32'd0);
        chk("wrap.result", resp_result, 32'd12);

        // Async reset between edges while a response is pending.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.req_ready", 32'(req_ready), 32'd0);
        chk_outs("areset", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, ALU_ADD, 32'd1, 32'd2, 1'b1);
        #1;
        chk("post_reset.req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk_outs("post_reset", 1'b1, 2'd0, 32'd3, 1'b0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
